// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encodings and default opcodes for the fetch sequencer
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH      = 3'd1,
        ST_DECODE     = 3'd2,
        ST_EXECUTE    = 3'd3,
        ST_FETCH_ADDR = 3'd4,
        ST_JUMP       = 3'd5,
        ST_HALTED     = 3'd6
    } state_t;

    localparam logic [3:0] DEF_OP_JMP = 4'hE;
    localparam logic [3:0] DEF_OP_HLT = 4'hF;

endpackage

// File: rtl/step_edge.sv
// rtl/step_edge.sv - two-flop rising-edge detector for the single-step input
module step_edge (
    input  logic clk,
    input  logic reset,
    input  logic step,
    output logic rise
);

    logic r_q1;
    logic r_q2;

    // Register step twice; a rise is new-high over old-low
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q1 <= 1'b0;
            r_q2 <= 1'b0;
        end else begin
            r_q1 <= step;
            r_q2 <= r_q1;
        end
    end

    assign rise = r_q1 & ~r_q2;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - Moore instruction fetch/decode sequencer; FETCH_SEQUENCER_SINGLE_STEP_EN adds step control
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int         ADDR_W = 12,
    parameter logic [3:0] OP_JMP = DEF_OP_JMP,
    parameter logic [3:0] OP_HLT = DEF_OP_HLT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
    input  logic              step,
`endif
    input  logic [3:0]        inst,
    input  logic [3:0]        oprnd,
    input  logic [7:0]        program_byte,
    output logic              enable_counter,
    output logic              enable_fetch,
    output logic              load_counter,
    output logic [ADDR_W-1:0] in_counter,
    output logic              exec_en,
    output logic              halted,
    output logic [2:0]        state
);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_target;
    logic [ADDR_W-1:0]   r_in_counter;
    logic [ADDR_W-9:0]   w_oprnd_ext;
    logic                w_start;
    logic                w_continue;

`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
    logic w_step_rise;

    step_edge u_step_edge (
        .clk   (clk),
        .reset (reset),
        .step  (step),
        .rise  (w_step_rise)
    );

    // Single-step: one instruction per step edge, always back to IDLE
    assign w_start    = run & w_step_rise;
    assign w_continue = 1'b0;
`else
    assign w_start    = run;
    assign w_continue = run;
`endif

    assign w_oprnd_ext = (ADDR_W-8)'(oprnd);

    // State register, reset forces IDLE without waiting for a clock
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; run only matters at instruction boundaries
    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE:       w_next = w_start ? ST_FETCH : ST_IDLE;
            ST_FETCH:      w_next = ST_DECODE;
            ST_DECODE: begin
                if (inst == OP_HLT)      w_next = ST_HALTED;
                else if (inst == OP_JMP) w_next = ST_FETCH_ADDR;
                else                     w_next = ST_EXECUTE;
            end
            ST_FETCH_ADDR: w_next = ST_JUMP;
            ST_JUMP,
            ST_EXECUTE:    w_next = w_continue ? ST_FETCH : ST_IDLE;
            ST_HALTED:     w_next = run ? ST_HALTED : ST_IDLE;
            default:       w_next = ST_IDLE;
        endcase
    end

    // Jump target assembly; in_counter is captured with the low byte so it holds after JUMP
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_target     <= '0;
            r_in_counter <= '0;
        end else begin
            if (w_next == ST_FETCH_ADDR && r_state == ST_DECODE)
                r_target[ADDR_W-1:8] <= w_oprnd_ext;
            if (r_state == ST_FETCH_ADDR) begin
                r_target[7:0] <= program_byte;
                r_in_counter  <= {r_target[ADDR_W-1:8], program_byte};
            end
        end
    end

    assign enable_fetch   = (r_state == ST_FETCH);
    assign enable_counter = (r_state == ST_FETCH) || (r_state == ST_FETCH_ADDR);
    assign load_counter   = (r_state == ST_JUMP);
    assign exec_en        = (r_state == ST_EXECUTE);
    assign halted         = (r_state == ST_HALTED);
    assign in_counter     = r_in_counter;
    assign state          = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench with program ROM, PC and fetch register around the sequencer
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        run;
    logic        step;
    logic [3:0]  inst;
    logic [3:0]  oprnd;
    logic [7:0]  program_byte;
    logic        enable_counter;
    logic        enable_fetch;
    logic        load_counter;
    logic [11:0] in_counter;
    logic        exec_en;
    logic        halted;
    logic [2:0]  state;

    logic [7:0]  rom [0:4095];
    logic [11:0] pc;
    logic [7:0]  fr;

    int n_cmp = 0;
    int n_err = 0;

    fetch_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .run            (run),
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
        .step           (step),
`endif
        .inst           (inst),
        .oprnd          (oprnd),
        .program_byte   (program_byte),
        .enable_counter (enable_counter),
        .enable_fetch   (enable_fetch),
        .load_counter   (load_counter),
        .in_counter     (in_counter),
        .exec_en        (exec_en),
        .halted         (halted),
        .state          (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Program counter and fetch register as the surrounding datapath would build them
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= 12'h000;
            fr <= 8'h00;
        end else begin
            if (load_counter)        pc <= in_counter;
            else if (enable_counter) pc <= pc + 12'h001;
            if (enable_fetch)        fr <= rom[pc];
        end
    end

    assign program_byte = rom[pc];
    assign inst         = fr[7:4];
    assign oprnd        = fr[3:0];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] dut_vec();
        return {state, enable_fetch, enable_counter, load_counter, exec_en, halted};
    endfunction

    // Output pattern each state must present
    function automatic logic [7:0] exp_vec(input logic [2:0] s);
        logic ef, ec, lc, ex, h;
        ef = (s == 3'd1);
        ec = (s == 3'd1) || (s == 3'd4);
        lc = (s == 3'd5);
        ex = (s == 3'd3);
        h  = (s == 3'd6);
        return {s, ef, ec, lc, ex, h};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    endtask

    task automatic do_reset();
        run   = 1'b0;
        step  = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]       b0;
        logic [7:0]       b1;
        logic [4:0][2:0]  seq;
        logic [11:0]      inc;
    } vec_t;

    typedef struct {
        logic [2:0]  st;
        logic [11:0] pc;
        logic [11:0] tgt;
    } trace_t;

    trace_t trq[$];

    // Instruction-level walk of the program producing the per-cycle state trace
    task automatic build_trace(input int n);
        logic [11:0] mpc;
        logic [7:0]  b, lo;
        logic [11:0] tgt;
        trq.delete();
        mpc = 12'h000;
        while (trq.size() < n) begin
            b = rom[mpc];
            trq.push_back('{3'd1, mpc, 12'h0});
            mpc = mpc + 12'h001;
            trq.push_back('{3'd2, 12'h0, 12'h0});
            if (b[7:4] == 4'hF) begin
                while (trq.size() < n) trq.push_back('{3'd6, 12'h0, 12'h0});
            end else if (b[7:4] == 4'hE) begin
                lo  = rom[mpc];
                mpc = mpc + 12'h001;
                tgt = {b[3:0], lo};
                trq.push_back('{3'd4, 12'h0, 12'h0});
                trq.push_back('{3'd5, 12'h0, tgt});
                mpc = tgt;
            end else begin
                trq.push_back('{3'd3, 12'h0, 12'h0});
            end
        end
    endtask

    vec_t tbl [5];

    initial begin
        int cnt;
        reset = 1'b0;
        run   = 1'b0;
        step  = 1'b0;
        clear_rom();

        // Reset state
        do_reset();
        chk("reset_vec", 32'(dut_vec()), 32'(exp_vec(3'd0)));
        chk("reset_inc", 32'(in_counter), 32'h0);

`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
        // One step edge runs exactly one instruction
        clear_rom();
        rom[0] = 8'h35;
        rom[1] = 8'h35;
        do_reset();
        run = 1'b1;
        repeat (5) tick();
        chk("ss_wait_idle", 32'(state), 32'd0);
        step = 1'b1;
        cnt  = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) step = 1'b0;
            tick();
            if (exec_en) cnt++;
        end
        chk("ss_one_exec", 32'(cnt), 32'd1);
        chk("ss_back_idle", 32'(state), 32'd0);
`else
        // Table of two-byte programs with the first five states after run
        tbl[0] = '{8'h35, 8'h00, {3'd2, 3'd1, 3'd3, 3'd2, 3'd1}, 12'h000};
        tbl[1] = '{8'hE1, 8'h23, {3'd1, 3'd5, 3'd4, 3'd2, 3'd1}, 12'h123};
        tbl[2] = '{8'hF0, 8'h00, {3'd6, 3'd6, 3'd6, 3'd2, 3'd1}, 12'h000};
        tbl[3] = '{8'h00, 8'h00, {3'd2, 3'd1, 3'd3, 3'd2, 3'd1}, 12'h000};
        tbl[4] = '{8'hEF, 8'hFF, {3'd1, 3'd5, 3'd4, 3'd2, 3'd1}, 12'hFFF};
        for (int t = 0; t < 5; t++) begin
            clear_rom();
            rom[0] = tbl[t].b0;
            rom[1] = tbl[t].b1;
            do_reset();
            run = 1'b1;
            for (int k = 0; k < 5; k++) begin
                tick();
                chk($sformatf("tbl%0d_c%0d", t, k), 32'(dut_vec()), 32'(exp_vec(tbl[t].seq[k])));
            end
            chk($sformatf("tbl%0d_inc", t), 32'(in_counter), 32'(tbl[t].inc));
        end

        // Async reset mid-FETCH, no clock edge needed
        clear_rom();
        rom[0] = 8'h35;
        do_reset();
        run = 1'b1;
        @(posedge clk);
        #2;
        chk("pre_async_fetch", 32'(state), 32'd1);
        reset = 1'b0;
        #1;
        chk("async_reset_vec", 32'(dut_vec()), 32'(exp_vec(3'd0)));
        reset = 1'b1;

        // Jump lands on target
        clear_rom();
        rom[0] = 8'hE1;
        rom[1] = 8'h23;
        do_reset();
        run = 1'b1;
        repeat (4) tick();
        chk("jmp_load", 32'({load_counter, enable_counter}), 32'b10);
        chk("jmp_inc", 32'(in_counter), 32'h123);
        tick();
        chk("jmp_fetch_pc", 32'(pc), 32'h123);
        chk("jmp_fetch_st", 32'(state), 32'd1);
        tick();
        chk("jmp_inc_hold", 32'(in_counter), 32'h123);

        // Second jump byte at PC wrap comes from address 0
        clear_rom();
        rom[0]     = 8'hEF;
        rom[1]     = 8'hFF;
        rom[12'hFFF] = 8'hE0;
        do_reset();
        run = 1'b1;
        repeat (5) tick();
        chk("wrap_fetch_pc", 32'(pc), 32'hFFF);
        repeat (3) tick();
        chk("wrap_jump_st", 32'(state), 32'd5);
        chk("wrap_inc", 32'(in_counter), 32'h0EF);

        // Halt held while run, then IDLE
        clear_rom();
        rom[0] = 8'hF0;
        do_reset();
        run = 1'b1;
        repeat (3) tick();
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (halted && state == 3'd6) cnt++;
            tick();
        end
        chk("halt_held", 32'(cnt), 32'd4);
        run = 1'b0;
        tick();
        chk("halt_exit", 32'(dut_vec()), 32'(exp_vec(3'd0)));

        // run dropped in DECODE still executes, then stays idle
        clear_rom();
        rom[0] = 8'h35;
        rom[1] = 8'h35;
        do_reset();
        run = 1'b1;
        repeat (2) tick();
        chk("drop_decode", 32'(state), 32'd2);
        run = 1'b0;
        tick();
        chk("drop_exec", 32'(dut_vec()), 32'(exp_vec(3'd3)));
        tick();
        chk("drop_idle", 32'(state), 32'd0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (enable_fetch) cnt++;
        end
        chk("drop_no_fetch", 32'(cnt), 32'd0);

        // Random programs against the instruction-level trace
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
            build_trace(50);
            do_reset();
            run = 1'b1;
            for (int k = 0; k < 50; k++) begin
                tick();
                chk($sformatf("rnd%0d_c%0d", r, k), 32'(dut_vec()), 32'(exp_vec(trq[k].st)));
                if (trq[k].st == 3'd1)
                    chk($sformatf("rnd%0d_pc%0d", r, k), 32'(pc), 32'(trq[k].pc));
                if (trq[k].st == 3'd5)
                    chk($sformatf("rnd%0d_tgt%0d", r, k), 32'(in_counter), 32'(trq[k].tgt));
            end
            run = 1'b0;
            cnt = 0;
            while (state != 3'd0 && cnt < 8) begin
                tick();
                cnt++;
            end
            chk($sformatf("rnd%0d_to_idle", r), 32'(state), 32'd0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
